// File: rtl/riscv_div_pkg.sv
// rtl/riscv_div_pkg.sv - opcodes, FSM states and cache entry shared by the divider front-end
package riscv_div_pkg;

  localparam logic [1:0] DIV_UDIV = 2'd0;
  localparam logic [1:0] DIV_DIV  = 2'd1;
  localparam logic [1:0] DIV_UREM = 2'd2;
  localparam logic [1:0] DIV_REM  = 2'd3;

  // Width of the cached operands/result; the cache is only built for this datapath width.
  localparam int unsigned DIV_CACHE_W = 32;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_ISSUE,
    DIV_WAIT,
    DIV_RESP
  } div_state_e;

  typedef struct packed {
    logic                   vld;
    logic [1:0]             op;
    logic [DIV_CACHE_W-1:0] a;
    logic [DIV_CACHE_W-1:0] b;
    logic [DIV_CACHE_W-1:0] res;
  } div_cache_t;

  function automatic logic div_is_signed(input logic [1:0] op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

endpackage

// File: rtl/riscv_div_lzc.sv
// rtl/riscv_div_lzc.sv - combinational leading-zero counter with all-zero flag
module riscv_div_lzc #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6
) (
  input  logic [C_WIDTH-1:0]     data_i,
  output logic [C_LOG_WIDTH-1:0] cnt_o,
  output logic                   zero_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt_o = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < int'(C_WIDTH); i++) begin
      if (data_i[i]) cnt_o = C_LOG_WIDTH'(int'(C_WIDTH) - 1 - i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/riscv_div_frontend.sv
// rtl/riscv_div_frontend.sv - request sequencer for the serial divider; DIV_RESULT_CACHE_EN adds a one-entry result cache
module riscv_div_frontend
  import riscv_div_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [1:0]             ReqOp_SI,
  output logic                   RspVld_SO,
  input  logic                   RspRdy_SI,
  output logic [C_WIDTH-1:0]     RspRes_DO,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  output logic                   DivOutRdy_SO,
  input  logic                   DivOutVld_SI,
  input  logic [C_WIDTH-1:0]     DivRes_DI
);

  div_state_e             state_q, state_d;
  logic                   req_rdy_q, req_rdy_d;
  logic                   rsp_vld_q, rsp_vld_d;
  logic                   div_in_vld_q, div_in_vld_d;
  logic                   div_out_rdy_q, div_out_rdy_d;
  logic [C_WIDTH-1:0]     a_q, a_d, b_q, b_d, opb_q, opb_d, res_q, res_d;
  logic [1:0]             op_q, op_d;
  logic [C_LOG_WIDTH-1:0] shift_q, shift_d;
  logic                   bzero_q, bzero_d, bsign_q, bsign_d;

  logic                   op_signed;
  logic [C_WIDTH-1:0]     lzc_in;
  logic [C_LOG_WIDTH-1:0] lzc_cnt, prep_shift;
  logic                   lzc_zero;
  logic                   cache_hit;
  logic [C_WIDTH-1:0]     cache_res;

  // Signed divisors count redundant sign bits so the sign stays at the msb.
  assign op_signed = div_is_signed(op_q);
  assign lzc_in    = op_signed ? (b_q ^ {C_WIDTH{b_q[C_WIDTH-1]}}) : b_q;

  riscv_div_lzc #(
    .C_WIDTH    (C_WIDTH),
    .C_LOG_WIDTH(C_LOG_WIDTH)
  ) i_lzc (
    .data_i(lzc_in),
    .cnt_o (lzc_cnt),
    .zero_o(lzc_zero)
  );

  always_comb begin
    prep_shift = lzc_cnt;
    if (lzc_zero)                             prep_shift = C_LOG_WIDTH'(C_WIDTH - 1);
    else if (op_signed && lzc_cnt == '0)      prep_shift = '0;
    else if (op_signed)                       prep_shift = lzc_cnt - C_LOG_WIDTH'(1);
  end

`ifdef DIV_RESULT_CACHE_EN
  div_cache_t cache_q, cache_d;

  assign cache_hit = cache_q.vld && (cache_q.op == ReqOp_SI) &&
                     (cache_q.a == DIV_CACHE_W'(ReqOpA_DI)) &&
                     (cache_q.b == DIV_CACHE_W'(ReqOpB_DI));
  assign cache_res = C_WIDTH'(cache_q.res);

  always_comb begin
    cache_d = cache_q;
    if (state_q == DIV_WAIT && DivOutVld_SI) begin
      cache_d.vld = 1'b1;
      cache_d.op  = op_q;
      cache_d.a   = DIV_CACHE_W'(a_q);
      cache_d.b   = DIV_CACHE_W'(b_q);
      cache_d.res = DIV_CACHE_W'(DivRes_DI);
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) cache_q <= '0;
    else          cache_q <= cache_d;
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_comb begin
    state_d       = state_q;
    req_rdy_d     = req_rdy_q;
    rsp_vld_d     = rsp_vld_q;
    div_in_vld_d  = 1'b0;
    div_out_rdy_d = div_out_rdy_q;
    a_d = a_q;  b_d = b_q;  op_d = op_q;  res_d = res_q;
    opb_d = opb_q;  shift_d = shift_q;  bzero_d = bzero_q;  bsign_d = bsign_q;
    unique case (state_q)
      DIV_IDLE: if (ReqVld_SI) begin
        a_d = ReqOpA_DI;  b_d = ReqOpB_DI;  op_d = ReqOp_SI;
        req_rdy_d = 1'b0;
        if (cache_hit) begin
          res_d     = cache_res;
          rsp_vld_d = 1'b1;
          state_d   = DIV_RESP;
        end else begin
          state_d   = DIV_PREP;
        end
      end
      DIV_PREP: begin
        shift_d      = prep_shift;
        opb_d        = b_q << prep_shift;
        bzero_d      = (b_q == '0);
        bsign_d      = op_q[0] & b_q[C_WIDTH-1];
        div_in_vld_d = 1'b1;
        state_d      = DIV_ISSUE;
      end
      DIV_ISSUE: begin
        div_out_rdy_d = 1'b1;
        state_d       = DIV_WAIT;
      end
      DIV_WAIT: if (DivOutVld_SI) begin
        res_d         = DivRes_DI;
        div_out_rdy_d = 1'b0;
        rsp_vld_d     = 1'b1;
        state_d       = DIV_RESP;
      end
      DIV_RESP: if (RspRdy_SI) begin
        rsp_vld_d = 1'b0;
        req_rdy_d = 1'b1;
        state_d   = DIV_IDLE;
      end
      default: begin
        rsp_vld_d     = 1'b0;
        div_out_rdy_d = 1'b0;
        req_rdy_d     = 1'b1;
        state_d       = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q       <= DIV_IDLE;
      req_rdy_q     <= 1'b1;
      rsp_vld_q     <= 1'b0;
      div_in_vld_q  <= 1'b0;
      div_out_rdy_q <= 1'b0;
      a_q <= '0;  b_q <= '0;  op_q <= '0;  res_q <= '0;
      opb_q <= '0;  shift_q <= '0;  bzero_q <= 1'b0;  bsign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_rdy_q     <= req_rdy_d;
      rsp_vld_q     <= rsp_vld_d;
      div_in_vld_q  <= div_in_vld_d;
      div_out_rdy_q <= div_out_rdy_d;
      a_q <= a_d;  b_q <= b_d;  op_q <= op_d;  res_q <= res_d;
      opb_q <= opb_d;  shift_q <= shift_d;  bzero_q <= bzero_d;  bsign_q <= bsign_d;
    end
  end

  assign ReqRdy_SO       = req_rdy_q;
  assign RspVld_SO       = rsp_vld_q;
  assign RspRes_DO       = res_q;
  assign DivOpA_DO       = a_q;
  assign DivOpB_DO       = opb_q;
  assign DivOpBShift_DO  = shift_q;
  assign DivOpBIsZero_SO = bzero_q;
  assign DivOpBSign_SO   = bsign_q;
  assign DivOpCode_SO    = op_q;
  assign DivInVld_SO     = div_in_vld_q;
  assign DivOutRdy_SO    = div_out_rdy_q;

endmodule

// File: tb/tb_riscv_div_frontend.sv
// tb/tb_riscv_div_frontend.sv - self-checking bench for riscv_div_frontend with a behavioural divider
module tb_riscv_div_frontend;

  localparam int W = 32;
`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [W-1:0] req_a, req_b, rsp_res, div_a, div_b, div_res;
  logic [1:0]   req_op, div_code;
  logic [5:0]   div_shift;
  logic         div_bzero, div_bsign, div_in_vld, div_out_rdy, div_out_vld;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_div_frontend #(.C_WIDTH(W), .C_LOG_WIDTH(6)) dut (
    .Clk_CI(clk), .Rst_RBI(rstn),
    .ReqVld_SI(req_vld), .ReqRdy_SO(req_rdy),
    .ReqOpA_DI(req_a), .ReqOpB_DI(req_b), .ReqOp_SI(req_op),
    .RspVld_SO(rsp_vld), .RspRdy_SI(rsp_rdy), .RspRes_DO(rsp_res),
    .DivOpA_DO(div_a), .DivOpB_DO(div_b), .DivOpBShift_DO(div_shift),
    .DivOpBIsZero_SO(div_bzero), .DivOpBSign_SO(div_bsign), .DivOpCode_SO(div_code),
    .DivInVld_SO(div_in_vld), .DivOutRdy_SO(div_out_rdy),
    .DivOutVld_SI(div_out_vld), .DivRes_DI(div_res)
  );

  // RISC-V M-extension division semantics.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    logic signed [W-1:0] sa, sb;
    logic ovf;
    sa = a; sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'd2:    return (b == 0) ? a : a % b;
      default: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
    endcase
  endfunction

  // Largest left shift that keeps the value (unsigned: no lost ones; signed: value preserved).
  function automatic int ref_shift(input logic [W-1:0] b, input logic [1:0] op);
    int n;
    logic [W-1:0] v;
    logic signed [W-1:0] t;
    if (b == 0) return W - 1;
    n = 0;
    if (!op[0]) begin
      v = b;
      while (!v[W-1]) begin v = v << 1; n++; end
    end else begin
      while (n < W - 1) begin
        t = b << (n + 1);
        if ((t >>> (n + 1)) != $signed(b)) break;
        n++;
      end
    end
    return n;
  endfunction

  // Divider model: raises OutVld in idle, runs Shift+1 DIVIDE cycles, then FINISH with the result.
  logic         dv_busy;
  int           dv_cnt;
  logic [W-1:0] dv_res, b_true;
  assign b_true = div_bzero ? '0 : (div_code[0] ? 32'($signed(div_b) >>> div_shift) : (div_b >> div_shift));

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dv_busy <= 1'b0; dv_cnt <= 0; dv_res <= '0;
    end else if (!dv_busy) begin
      if (div_in_vld) begin
        dv_busy <= 1'b1;
        dv_cnt  <= int'(div_shift) + 1;
        dv_res  <= ref_res(div_a, b_true, div_code);
      end
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
    end else if (div_out_rdy) begin
      dv_busy <= 1'b0;
    end
  end
  assign div_out_vld = !dv_busy || (dv_cnt == 0);
  assign div_res     = dv_busy ? dv_res : 32'hDEAD_BEEF;

  task automatic apply_reset();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); @(negedge clk); rstn = 1'b1;
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input int hold,
                         output int lat, output logic [W-1:0] res, output int issued,
                         output int sh, output logic [W-1:0] ob, output logic sg, output logic zr,
                         output logic leak, output logic unstable);
    int guard;
    lat = 0; res = '0; issued = 0; sh = 0; ob = '0; sg = 0; zr = 0; leak = 0; unstable = 0;
    @(negedge clk);
    req_vld = 1'b1; req_a = a; req_b = b; req_op = op; rsp_rdy = (hold == 0);
    guard = 0;
    while (!req_rdy && guard < 100) begin @(negedge clk); guard++; end
    total++;
    if (!req_rdy) begin bad++; $display("FAIL req_rdy_timeout got=%0b want=1", req_rdy); end
    @(posedge clk); #1;
    req_vld = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
    lat = 1; guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      if (div_in_vld) begin
        issued++; sh = int'(div_shift); ob = div_b; sg = div_bsign; zr = div_bzero;
      end
      if (rsp_vld) break;
      if (req_rdy) leak = 1'b1;
      @(posedge clk); lat++; guard++;
    end
    total++;
    if (!rsp_vld) begin bad++; $display("FAIL rsp_timeout got=%0b want=1", rsp_vld); end
    res = rsp_res;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_res !== res || !rsp_vld) unstable = 1'b1;
      if (req_rdy) leak = 1'b1;
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++;
    if ({req_rdy, rsp_vld, div_in_vld, div_out_rdy} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=1000", {req_rdy, rsp_vld, div_in_vld, div_out_rdy});
    end
    total++;
    if ({rsp_res, div_a, div_b} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", rsp_res, div_a, div_b);
    end
    total++;
    if ({div_shift, div_bzero, div_bsign, div_code} !== '0) begin
      bad++; $display("FAIL reset_flags got=%h want=0", {div_shift, div_bzero, div_bsign, div_code});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] a[4], b[4], xr[4], xob[4], res, ob;
    logic [1:0]   op[4];
    int           xsh[4], xlat[4], hold[4], lat, iss, sh;
    logic         xz[4], sg, zr, leak, unst;
    a  = '{100, 32'hFFFF_FFF9, 5, 9};     b   = '{7, 2, 0, 4};       op = '{0, 3, 0, 2};
    xr = '{14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1};
    xsh = '{29, 29, 31, 29};  xob = '{32'hE000_0000, 32'h4000_0000, 0, 32'h8000_0000};
    xz  = '{0, 0, 1, 0};      xlat = '{34, 34, 36, 34};  hold = '{0, 0, 0, 10};
    for (int k = 0; k < 4; k++) begin
      run_job(a[k], b[k], op[k], hold[k], lat, res, iss, sh, ob, sg, zr, leak, unst);
      total++; if (res !== xr[k])  begin bad++; $display("FAIL dir%0d_res got=%h want=%h", k, res, xr[k]); end
      total++; if (sh != xsh[k])   begin bad++; $display("FAIL dir%0d_shift got=%0d want=%0d", k, sh, xsh[k]); end
      total++; if (ob !== xob[k])  begin bad++; $display("FAIL dir%0d_opb got=%h want=%h", k, ob, xob[k]); end
      total++; if (zr !== xz[k] || sg !== 1'b0) begin bad++; $display("FAIL dir%0d_flags got=z%b s%b want=z%b s0", k, zr, sg, xz[k]); end
      total++; if (lat != xlat[k]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, xlat[k]); end
      total++; if (leak || unst)   begin bad++; $display("FAIL dir%0d_hold got=leak%b unstable%b want=0/0", k, leak, unst); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res, ob;
    int           lat, iss, sh, guard;
    logic         sg, zr, leak, unst;
    @(negedge clk); req_vld = 1'b1; req_a = 1000; req_b = 3; req_op = 2'd0;
    @(posedge clk); #1 req_vld = 1'b0;
    guard = 0;
    while (!div_out_rdy && guard < 20) begin @(negedge clk); guard++; end
    total++; if (!div_out_rdy) begin bad++; $display("FAIL mid_wait_reached got=%b want=1", div_out_rdy); end
    repeat (3) @(negedge clk);
    rstn = 1'b0; #1;
    total++;
    if ({req_rdy, rsp_vld, div_in_vld, div_out_rdy} !== 4'b1000 ||
        {rsp_res, div_a, div_b, div_shift, div_bzero, div_bsign, div_code} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs got=%b res=%h a=%h want=1000 zeros", {req_rdy, rsp_vld, div_in_vld, div_out_rdy}, rsp_res, div_a);
    end
    @(negedge clk); rstn = 1'b1;
    run_job(8, 2, 2'd0, 0, lat, res, iss, sh, ob, sg, zr, leak, unst);
    total++; if (res !== 32'd4) begin bad++; $display("FAIL mid_after_res got=%0d want=4", res); end
    total++; if (lat != 35)     begin bad++; $display("FAIL mid_after_latency got=%0d want=35", lat); end
  endtask

  task automatic test_repeat();
    logic [W-1:0] res, ob;
    int           lat, iss, sh;
    logic         sg, zr, leak, unst;
    run_job(100, 7, 2'd0, 0, lat, res, iss, sh, ob, sg, zr, leak, unst);
    run_job(100, 7, 2'd0, 0, lat, res, iss, sh, ob, sg, zr, leak, unst);
    total++; if (res !== 32'd14) begin bad++; $display("FAIL rep_res got=%0d want=14", res); end
    total++; if (lat != (CACHE_ON ? 1 : 34)) begin bad++; $display("FAIL rep_latency got=%0d want=%0d", lat, CACHE_ON ? 1 : 34); end
    total++; if (iss != (CACHE_ON ? 0 : 1))  begin bad++; $display("FAIL rep_issued got=%0d want=%0d", iss, CACHE_ON ? 0 : 1); end
    apply_reset();
    run_job(100, 7, 2'd0, 0, lat, res, iss, sh, ob, sg, zr, leak, unst);
    total++; if (lat != 34 || iss != 1 || res !== 32'd14) begin
      bad++; $display("FAIL rep_after_reset got=lat%0d iss%0d res%0d want=lat34 iss1 res14", lat, iss, res);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, ob, la, lb;
    logic [1:0]   op, lop;
    int           lat, iss, sh, xsh, xlat;
    logic         sg, zr, leak, unst, lvld, hit;
    apply_reset();
    lvld = 1'b0; la = '0; lb = '0; lop = '0;
    for (int n = 0; n < 40; n++) begin
      if (lvld && $urandom_range(0, 3) == 0) begin
        a = la; b = lb; op = lop;
      end else begin
        op = 2'($urandom);
        a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
        case ($urandom_range(0, 5))
          0:       b = '0;
          1:       b = 32'hFFFF_FFFF;
          2:       b = $urandom_range(1, 15);
          3:       b = 32'h8000_0000;
          default: b = $urandom;
        endcase
      end
      hit = CACHE_ON && lvld && a == la && b == lb && op == lop;
      xsh = ref_shift(b, op);
      xlat = hit ? 1 : 5 + xsh;
      run_job(a, b, op, $urandom_range(0, 2), lat, res, iss, sh, ob, sg, zr, leak, unst);
      total++; if (res !== ref_res(a, b, op)) begin bad++; $display("FAIL rnd%0d_res op=%0d a=%h b=%h got=%h want=%h", n, op, a, b, res, ref_res(a, b, op)); end
      total++; if (lat != xlat) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, xlat); end
      total++; if (iss != (hit ? 0 : 1)) begin bad++; $display("FAIL rnd%0d_issued got=%0d want=%0d", n, iss, hit ? 0 : 1); end
      if (!hit) begin
        total++; if (sh != xsh) begin bad++; $display("FAIL rnd%0d_shift op=%0d b=%h got=%0d want=%0d", n, op, b, sh, xsh); end
        total++; if (ob !== (b << xsh)) begin bad++; $display("FAIL rnd%0d_opb got=%h want=%h", n, ob, b << xsh); end
        total++; if (sg !== (op[0] & b[W-1]) || zr !== (b == 0)) begin
          bad++; $display("FAIL rnd%0d_flags got=s%b z%b want=s%b z%b", n, sg, zr, op[0] & b[W-1], b == 0);
        end
        lvld = 1'b1; la = a; lb = b; lop = op;
      end
      total++; if (leak || unst) begin bad++; $display("FAIL rnd%0d_hold got=leak%b unstable%b want=0/0", n, leak, unst); end
    end
  endtask

  initial begin
    rstn = 1'b0; req_vld = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    test_directed();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
